// File: rtl/pattern_scan_arbiter_if.sv
// pattern_scan_arbiter_if: requester job bus and result handshake for the pattern scan arbiter.
interface pattern_scan_arbiter_if #(
  parameter int NREQ = 4,
  parameter int DATA_W = 16,
  parameter int ID_W = $clog2(NREQ),
  parameter int CNT_W = $clog2(DATA_W + 1)
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*4-1:0] req_pattern;
  logic [NREQ*DATA_W-1:0] req_data;
  logic resp_valid;
  logic resp_ready;
  logic [ID_W-1:0] resp_id;
  logic [CNT_W-1:0] resp_count;
  logic busy;
  modport master (
    output req_valid, req_pattern, req_data, resp_ready,
    input req_ready, resp_valid, resp_id, resp_count, busy
  );
  modport slave (
    input req_valid, req_pattern, req_data, resp_ready,
    output req_ready, resp_valid, resp_id, resp_count, busy
  );
endinterface

// File: rtl/pattern_scan_arbiter.sv
// pattern_scan_arbiter: round-robin job grant, MSB-first serial 4-bit overlapping pattern count.
module pattern_scan_arbiter #(
  parameter int NREQ = 4,
  parameter int DATA_W = 16,
  parameter int ID_W = $clog2(NREQ),
  parameter int CNT_W = $clog2(DATA_W + 1)
) (
  input logic clk,
  input logic rst,
  pattern_scan_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  state_t state_q;
  logic [ID_W-1:0] last_q, id_q, gnt_d;
  logic [3:0] pat_q;
  logic [DATA_W-1:0] data_q;
  logic [2:0] hist_q;
  logic [IDX_W-1:0] idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic valid_q, busy_q, found_d, bit_d, match_d;
  // Lowest valid overall is the wrap-around fallback; lowest valid above last_q overrides it.
  always_comb begin
    found_d = 1'b0;
    gnt_d = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k]) begin
        found_d = 1'b1;
        gnt_d = ID_W'(k);
      end
    end
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[k] && ID_W'(k) > last_q) gnt_d = ID_W'(k);
    end
  end
  assign bit_d = data_q[DATA_W-1];
  assign match_d = (idx_q >= IDX_W'(3)) && ({hist_q, bit_d} == pat_q);
  assign bus.req_ready = (state_q == IDLE && found_d) ? NREQ'(1) << gnt_d : '0;
  assign bus.resp_valid = valid_q;
  assign bus.resp_id = id_q;
  assign bus.resp_count = cnt_q;
  assign bus.busy = busy_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= ID_W'(NREQ - 1);
      id_q <= '0;
      cnt_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      pat_q <= '0;
      data_q <= '0;
      hist_q <= '0;
      idx_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (found_d) begin
          state_q <= SHIFT;
          busy_q <= 1'b1;
          id_q <= gnt_d;
          pat_q <= 4'(bus.req_pattern >> (4 * gnt_d));
          data_q <= DATA_W'(bus.req_data >> (DATA_W * gnt_d));
          hist_q <= '0;
          idx_q <= '0;
          cnt_q <= '0;
        end
        SHIFT: begin
          hist_q <= {hist_q[1:0], bit_d};
          data_q <= data_q << 1;
          idx_q <= idx_q + IDX_W'(1);
          cnt_q <= cnt_q + CNT_W'(match_d);
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            state_q <= RESP;
            valid_q <= 1'b1;
          end
        end
        RESP: if (bus.resp_ready) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q <= 1'b0;
          last_q <= id_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// tb_pattern_scan_arbiter: directed jobs with a scoreboard of expected id/count pairs.
module tb_pattern_scan_arbiter;
  localparam int NREQ = 4;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int exp_id_q[$];
  int exp_cnt_q[$];
  int lat;
  int e_cnt;
  logic [3:0] pats [4] = '{4'b1010, 4'b0000, 4'b0110, 4'b1001};
  logic [15:0] datas [4] = '{16'hA5A5, 16'h0F00, 16'h6C36, 16'h9999};
  always #5 clk = ~clk;
  pattern_scan_arbiter_if #(.NREQ(NREQ), .DATA_W(DW)) bus();
  pattern_scan_arbiter #(.NREQ(NREQ), .DATA_W(DW)) dut (.clk(clk), .rst(rst), .bus(bus));
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  function automatic int model(logic [3:0] p, logic [15:0] d);
    int c = 0;
    for (int k = 3; k < 16; k++) if (d[15-k +: 4] == p) c++;
    return c;
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(int i, logic [3:0] p, logic [15:0] d);
    bus.req_pattern = (bus.req_pattern & ~(16'hF << (4 * i))) | (16'(p) << (4 * i));
    bus.req_data = (bus.req_data & ~(64'hFFFF << (DW * i))) | (64'(d) << (DW * i));
  endtask
  task automatic expect_job(int i, logic [3:0] p, logic [15:0] d);
    exp_id_q.push_back(i);
    exp_cnt_q.push_back(model(p, d));
  endtask
  task automatic wait_ready();
    int n = 0;
    while (bus.req_ready == '0 && n < 50) begin
      cyc();
      n++;
    end
  endtask
  task automatic pop_check();
    chk("sb_nonempty", exp_id_q.size() != 0, 1);
    if (exp_id_q.size() != 0) begin
      chk("resp_id", bus.resp_id, exp_id_q.pop_front());
      chk("resp_count", bus.resp_count, exp_cnt_q.pop_front());
    end
  endtask
  task automatic finish_job(output int n);
    n = 1;
    while (!bus.resp_valid && n < 100) begin
      cyc();
      n++;
    end
    chk("resp_seen", bus.resp_valid, 1);
    if (bus.resp_valid) pop_check();
    cyc();
  endtask
  task automatic do_job(int i, logic [3:0] p, logic [15:0] d, bit mutate, output int n);
    set_req(i, p, d);
    bus.req_valid = bus.req_valid | (4'b1 << i);
    expect_job(i, p, d);
    #1;
    wait_ready();
    chk("req_ready", bus.req_ready, 1 << i);
    cyc();
    bus.req_valid = bus.req_valid & ~(4'b1 << i);
    chk("busy", bus.busy, 1);
    if (mutate) begin
      repeat (5) cyc();
      set_req(i, ~p, ~d);
      finish_job(n);
      n += 5;
    end else finish_job(n);
  endtask
  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_pattern = '0;
    bus.req_data = '0;
    bus.resp_ready = 1'b1;
    cyc();
    cyc();
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_id", bus.resp_id, 0);
    chk("rst_resp_count", bus.resp_count, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    do_job(0, 4'b1010, 16'hAAAA, 1'b0, lat);
    chk("latency", lat, 17);
    chk("idle_after_hs", bus.resp_valid, 0);
    do_job(2, 4'b0000, 16'h0000, 1'b0, lat);
    do_job(2, 4'b1111, 16'hFFFF, 1'b0, lat);
    do_job(3, 4'b0110, 16'h6666, 1'b1, lat);
    for (int i = 0; i < NREQ; i++) set_req(i, pats[i], datas[i]);
    for (int k = 0; k < 5; k++) expect_job(k % 4, pats[k % 4], datas[k % 4]);
    bus.req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      wait_ready();
      chk("rr_order", bus.req_ready, 1 << (k % 4));
      cyc();
      if (k == 4) bus.req_valid = '0;
      finish_job(lat);
    end
    bus.resp_ready = 1'b0;
    set_req(2, 4'b1001, 16'h9249);
    e_cnt = model(4'b1001, 16'h9249);
    bus.req_valid = 4'b0100;
    expect_job(2, 4'b1001, 16'h9249);
    #1;
    wait_ready();
    chk("req_ready_r2", bus.req_ready, 4'b0100);
    cyc();
    set_req(1, 4'b0011, 16'h3333);
    bus.req_valid = 4'b0010;
    finish_job(lat);
    repeat (5) begin
      chk("hold_valid", bus.resp_valid, 1);
      chk("hold_id", bus.resp_id, 2);
      chk("hold_count", bus.resp_count, e_cnt);
      chk("hold_ready", bus.req_ready, 0);
      cyc();
    end
    bus.resp_ready = 1'b1;
    expect_job(1, 4'b0011, 16'h3333);
    cyc();
    chk("post_hs_ready", bus.req_ready, 4'b0010);
    cyc();
    bus.req_valid = '0;
    finish_job(lat);
    set_req(3, 4'b0101, 16'h5555);
    bus.req_valid = 4'b1000;
    #1;
    wait_ready();
    chk("req_ready_r3", bus.req_ready, 4'b1000);
    cyc();
    bus.req_valid = '0;
    repeat (8) cyc();
    rst = 1'b1;
    cyc();
    chk("mid_rst_req_ready", bus.req_ready, 0);
    chk("mid_rst_resp_valid", bus.resp_valid, 0);
    chk("mid_rst_resp_id", bus.resp_id, 0);
    chk("mid_rst_resp_count", bus.resp_count, 0);
    chk("mid_rst_busy", bus.busy, 0);
    rst = 1'b0;
    set_req(0, 4'b1100, 16'hCCC3);
    set_req(3, 4'b0001, 16'h1111);
    bus.req_valid = 4'b1001;
    expect_job(0, 4'b1100, 16'hCCC3);
    #1;
    chk("post_rst_grant", bus.req_ready, 4'b0001);
    cyc();
    bus.req_valid = '0;
    finish_job(lat);
    chk("sb_empty", exp_id_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
